// File: rtl/vgs_pkg.sv
// Shared constants and FSM state encoding for the VGS PWM scheduler.
package vgs_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned MIN_ON     = 3;
    localparam int unsigned MIN_OFF    = 3;
    localparam int unsigned PERIOD_MIN = 8;
    localparam int unsigned SS_STEP    = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } vgs_state_e;

endpackage

// File: rtl/vgs_pwm_scheduler_if.sv
// Config handshake bundle: the host offers period/on-time, the scheduler accepts.
interface vgs_pwm_scheduler_if #(
    parameter int unsigned CNT_W = vgs_pkg::CNT_W
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_on;

    modport master (output cfg_valid, output cfg_period, output cfg_on, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_period, input  cfg_on, output cfg_ready);

endinterface

// File: rtl/vgs_period_counter.sv
// Period counter: counts 0..period-1 while running, held at 0 otherwise,
// and flags the first cycle of every period.
module vgs_period_counter #(
    parameter int unsigned CNT_W = vgs_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             keep_i,
    input  logic [CNT_W-1:0] period_i,
    output logic [CNT_W-1:0] cnt_d_c,
    output logic             wrap_c,
    output logic             period_start_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             period_start_q;

    assign wrap_c = run_i && (cnt_q == period_i - CNT_W'(1));

    // run_i: counting this cycle; keep_i: still counting next cycle
    always_comb begin
        cnt_d_c = '0;
        if (keep_i && run_i && !wrap_c) begin
            cnt_d_c = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d_c;
            period_start_q <= keep_i && (cnt_d_c == '0);
        end
    end

    assign period_start_o = period_start_q;

endmodule

// File: rtl/vgs_pwm_scheduler.sv
// PWM drive scheduler for vgs_controller: config shadowing and clamping,
// soft-start ramp, graceful stop at period end and latched fault handling.
module vgs_pwm_scheduler
    import vgs_pkg::vgs_state_e, vgs_pkg::ST_IDLE, vgs_pkg::ST_SOFTSTART,
           vgs_pkg::ST_RUN, vgs_pkg::ST_FAULT;
#(
    parameter int unsigned CNT_W      = vgs_pkg::CNT_W,
    parameter int unsigned MIN_ON     = vgs_pkg::MIN_ON,
    parameter int unsigned MIN_OFF    = vgs_pkg::MIN_OFF,
    parameter int unsigned PERIOD_MIN = vgs_pkg::PERIOD_MIN,
    parameter int unsigned SS_STEP    = vgs_pkg::SS_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    vgs_pwm_scheduler_if.slave cfg,
    input  logic               fault,
    input  logic               fault_clr,
    output logic               pwm_out,
    output logic               period_start,
    output logic [1:0]         state,
    output logic               fault_latched
);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : p;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_on(input logic [CNT_W-1:0] on,
                                                  input logic [CNT_W-1:0] per);
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;
        lo = (on < CNT_W'(MIN_ON)) ? CNT_W'(MIN_ON) : on;
        hi = per - CNT_W'(MIN_OFF);
        if (on == '0) return '0;
        return (lo > hi) ? hi : lo;
    endfunction

    function automatic logic [CNT_W-1:0] ss_floor(input logic [CNT_W-1:0] tgt);
        return (tgt < CNT_W'(MIN_ON)) ? tgt : CNT_W'(MIN_ON);
    endfunction

    function automatic logic [CNT_W-1:0] ss_step(input logic [CNT_W-1:0] act,
                                                 input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] sum;
        sum = {1'b0, act} + (CNT_W+1)'(SS_STEP);
        return (sum > {1'b0, tgt}) ? tgt : sum[CNT_W-1:0];
    endfunction

    function automatic logic big_jump(input logic [CNT_W-1:0] act,
                                      input logic [CNT_W-1:0] tgt);
        return {1'b0, tgt} > ({1'b0, act} + (CNT_W+1)'(4 * SS_STEP));
    endfunction

    vgs_state_e       state_q, state_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] on_tgt_q, on_tgt_d;
    logic [CNT_W-1:0] on_act_q, on_act_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d;
    logic [CNT_W-1:0] pend_on_q, pend_on_d;
    logic             pwm_q, pwm_d;
    logic             fault_latched_q, fault_latched_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             xfer_c;
    logic [CNT_W-1:0] cfg_period_c;
    logic [CNT_W-1:0] cfg_on_c;
    logic             run_q_c;
    logic             run_d_c;
    logic [CNT_W-1:0] cnt_d_c;
    logic             wrap_c;

    assign xfer_c       = cfg.cfg_valid && cfg_ready_q;
    assign cfg_period_c = clamp_period(cfg.cfg_period);
    assign cfg_on_c     = clamp_on(cfg.cfg_on, cfg_period_c);
    assign run_q_c      = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
    assign run_d_c      = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);

    vgs_period_counter #(.CNT_W(CNT_W)) u_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_i          (run_q_c),
        .keep_i         (run_d_c),
        .period_i       (act_period_q),
        .cnt_d_c        (cnt_d_c),
        .wrap_c         (wrap_c),
        .period_start_o (period_start)
    );

    // Next state; pending config is promoted at entry and at every wrap,
    // a same-cycle transfer included.
    always_comb begin
        state_d       = state_q;
        act_period_d  = act_period_q;
        on_tgt_d      = on_tgt_q;
        on_act_d      = on_act_q;
        pend_period_d = xfer_c ? cfg_period_c : pend_period_q;
        pend_on_d     = xfer_c ? cfg_on_c     : pend_on_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    act_period_d = pend_period_d;
                    on_tgt_d     = pend_on_d;
                    on_act_d     = ss_floor(pend_on_d);
                    state_d      = (pend_on_d == '0) ? ST_RUN : ST_SOFTSTART;
                end
            end
            ST_SOFTSTART, ST_RUN: begin
                if (wrap_c) begin
                    act_period_d = pend_period_d;
                    on_tgt_d     = pend_on_d;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_SOFTSTART) begin
                        on_act_d = ss_step(on_act_q, pend_on_d);
                        if (on_act_d == pend_on_d) state_d = ST_RUN;
                    end else if (big_jump(on_act_q, pend_on_d)) begin
                        on_act_d = ss_floor(pend_on_d);
                        state_d  = ST_SOFTSTART;
                    end else begin
                        on_act_d = pend_on_d;
                    end
                end
            end
            ST_FAULT: begin
                if (!fault && fault_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fault) state_d = ST_FAULT;
    end

    assign pwm_d           = run_d_c && (cnt_d_c < on_act_d);
    assign fault_latched_d = (state_d == ST_FAULT);
    assign cfg_ready_d     = (state_d != ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            act_period_q    <= CNT_W'(PERIOD_MIN);
            on_tgt_q        <= '0;
            on_act_q        <= '0;
            pend_period_q   <= CNT_W'(PERIOD_MIN);
            pend_on_q       <= '0;
            pwm_q           <= 1'b0;
            fault_latched_q <= 1'b0;
            cfg_ready_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            act_period_q    <= act_period_d;
            on_tgt_q        <= on_tgt_d;
            on_act_q        <= on_act_d;
            pend_period_q   <= pend_period_d;
            pend_on_q       <= pend_on_d;
            pwm_q           <= pwm_d;
            fault_latched_q <= fault_latched_d;
            cfg_ready_q     <= cfg_ready_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign state         = 2'(state_q);
    assign fault_latched = fault_latched_q;
    assign cfg.cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_vgs_pwm_scheduler.sv
// Directed bench for vgs_pwm_scheduler with hand-computed waveform expectations.
module tb_vgs_pwm_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic fault = 1'b0;
    logic fault_clr = 1'b0;
    logic pwm_out;
    logic period_start;
    logic [1:0] state;
    logic fault_latched;

    int n_checks = 0;
    int n_fail = 0;
    int h, h2, fl;

    vgs_pwm_scheduler_if cfg_if ();

    vgs_pwm_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg           (cfg_if),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwm_out       (pwm_out),
        .period_start  (period_start),
        .state         (state),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int per, input int on);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = 16'(per);
        cfg_if.cfg_on     = 16'(on);
        tick();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    // Samples n cycles starting with the current one; first_low = n if never low.
    task automatic measure(input int n, output int highs, output int first_low);
        highs = 0;
        first_low = n;
        for (int i = 0; i < n; i++) begin
            if (pwm_out === 1'b1) highs++;
            else if (first_low == n) first_low = i;
            tick();
        end
    endtask

    task automatic wait_ps(input string tag, input int budget);
        int n = 0;
        while (period_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, int'(period_start), 1);
    endtask

    task automatic wait_state(input string tag, input int exp, input int budget);
        int n = 0;
        while (int'(state) != exp && n < budget) begin
            tick();
            n++;
        end
        chk(tag, int'(state), exp);
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_on     = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_state", int'(state), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_fault_latched", int'(fault_latched), 0);
        chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
        rst_n = 1'b1;
        tick();

        // 20/10: soft-start 3..10 over 8 periods, then steady RUN
        send_cfg(20, 10);
        chk("idle_no_enable", int'(state), 0);
        chk("idle_cfg_ready", int'(cfg_if.cfg_ready), 1);
        enable = 1'b1;
        tick();
        chk("ss_entry_pwm", int'(pwm_out), 1);
        for (int p = 1; p <= 8; p++) begin
            chk("ss_period_start", int'(period_start), 1);
            chk("ss_state", int'(state), (p == 8) ? 2 : 1);
            measure(20, h, fl);
            chk("ss_high_cycles", h, p + 2);
            chk("ss_contiguous", fl, p + 2);
        end
        for (int p = 0; p < 2; p++) begin
            measure(20, h, fl);
            chk("run_high_cycles", h, 10);
            chk("run_contiguous", fl, 10);
        end

        // cfg 4/1 clamps to period 8, on 3
        send_cfg(4, 1);
        wait_ps("clamp_boundary", 40);
        measure(8, h, fl);
        chk("clamp_high", h, 3);
        chk("clamp_contiguous", fl, 3);
        chk("clamp_period8", int'(period_start), 1);
        chk("clamp_state", int'(state), 2);

        // cfg 20/19 clamps on to 17; jump of 14 re-enters soft-start
        send_cfg(20, 19);
        wait_ps("max_boundary", 40);
        chk("max_reenter_ss", int'(state), 1);
        wait_state("max_run", 2, 500);
        measure(20, h, fl);
        chk("max_high", h, 17);
        chk("max_contiguous", fl, 17);
        chk("max_low3_next_high", int'(pwm_out), 1);

        // Decrease to 10 tracked directly, then enable dropped at cnt=2
        send_cfg(20, 10);
        wait_ps("stop_boundary", 40);
        chk("stop_run_state", int'(state), 2);
        measure(2, h, fl);
        enable = 1'b0;
        measure(18, h2, fl);
        chk("stop_full_pulse", h + h2, 10);
        chk("stop_idle", int'(state), 0);
        chk("stop_pwm_low", int'(pwm_out), 0);

        // Fault mid-high in RUN
        enable = 1'b1;
        tick();
        wait_state("fault_run", 2, 400);
        measure(3, h, fl);
        chk("fault_pre_high", int'(pwm_out), 1);
        fault = 1'b1;
        tick();
        chk("fault_pwm", int'(pwm_out), 0);
        chk("fault_state", int'(state), 3);
        chk("fault_latched", int'(fault_latched), 1);
        chk("fault_cfg_ready", int'(cfg_if.cfg_ready), 0);
        fault_clr = 1'b1;
        tick();
        chk("fault_clr_with_fault", int'(state), 3);
        fault = 1'b0;
        fault_clr = 1'b0;
        tick();
        chk("fault_hold_no_clr", int'(state), 3);
        fault_clr = 1'b1;
        tick();
        chk("fault_cleared_idle", int'(state), 0);
        chk("fault_cleared_latched", int'(fault_latched), 0);
        chk("fault_cleared_ready", int'(cfg_if.cfg_ready), 1);
        fault_clr = 1'b0;
        enable = 1'b0;
        tick();

        // on=0 goes straight to RUN; transfer on the wrap cycle applies at once
        send_cfg(10, 0);
        enable = 1'b1;
        tick();
        chk("zero_on_run", int'(state), 2);
        chk("zero_on_ps", int'(period_start), 1);
        measure(9, h, fl);
        chk("zero_on_high", h, 0);
        send_cfg(12, 4);
        chk("wrap_xfer_ps", int'(period_start), 1);
        chk("wrap_xfer_pwm", int'(pwm_out), 1);
        chk("wrap_xfer_state", int'(state), 2);
        measure(12, h, fl);
        chk("wrap_xfer_high", h, 4);
        chk("wrap_xfer_contiguous", fl, 4);
        chk("wrap_xfer_period12", int'(period_start), 1);

        // Asynchronous reset mid-pulse
        tick();
        chk("arst_pre_high", int'(pwm_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_ps", int'(period_start), 0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", int'(state), 0);

        // Reset pending config is period 8, on 0
        enable = 1'b1;
        tick();
        chk("post_rst_run", int'(state), 2);
        measure(8, h, fl);
        chk("post_rst_high", h, 0);
        chk("post_rst_period8", int'(period_start), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
